rob_superscalar: RTL and testbench

ROB_SUPERSCALAR -- requirements
Module: rob_superscalar

---
 rtl/rv32i_types.sv | 21 ++
 rtl/rob_commit_select.sv | 42 ++++
 rtl/rob_superscalar.sv | 215 +++++++++++++++++++++
 tb/tb_rob_superscalar.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the out-of-order core slice.
// Provides:
//   PREG_W      - physical register index width
//   rob_entry_t - per-instruction payload written at dispatch
//   idx_w()     - ROB index width for a given entry count
package rv32i_types;

  localparam int PREG_W = 6;

  typedef struct packed {
    logic [4:0]        areg_index;
    logic [PREG_W-1:0] preg_index;
    logic              is_branch;
  } rob_entry_t;

  // Index width for a ROB of 'depth' entries (depth is a power of two).
  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Retire-lane selection for the reorder buffer.
// Lane j looks at entry (head+j). A lane retires only when every older lane
// retires and its own entry is occupied and done. A retiring entry that
// redirects control flow closes the group: younger lanes are held back.
// Ports:
//   lane_occupied/lane_done/lane_redirect - registered state of entries head+j
//   retire       - per-lane retire decision (contiguous from lane 0)
//   retire_count - number of lanes retiring
//   redirect_hit - a retiring lane carries a redirect
module rob_commit_select #(
  parameter int COMMIT_W = 2
) (
  input  logic [COMMIT_W-1:0] lane_occupied,
  input  logic [COMMIT_W-1:0] lane_done,
  input  logic [COMMIT_W-1:0] lane_redirect,
  output logic [COMMIT_W-1:0] retire,
  output logic [2:0]          retire_count,
  output logic                redirect_hit
);

  logic go;

  always_comb begin
    retire       = '0;
    retire_count = '0;
    redirect_hit = 1'b0;
    go           = 1'b1;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (go && lane_occupied[j] && lane_done[j]) begin
        retire[j]    = 1'b1;
        retire_count = retire_count + 3'd1;
        if (lane_redirect[j]) begin
          redirect_hit = 1'b1;
          go           = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_superscalar.sv
// Superscalar reorder buffer.
// Accepts up to DISP_W instructions per cycle at the tail, marks entries done
// from CDB_PORTS completion ports, and retires up to COMMIT_W done entries per
// cycle in program order from the head. Retiring a redirecting instruction
// raises a one-cycle flush and empties the buffer on the same edge.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   enq_valid/entry/ready    - dispatch group (contiguous from slot 0)
//   enq_idx                  - entry index each dispatch slot receives
//   cdb_*                    - completion broadcasts
//   commit_valid/rd/pd       - registered retire lanes
//   flush, flush_pc          - registered redirect pulse and target
//   head_idx, count          - oldest entry index and occupancy
module rob_superscalar
  import rv32i_types::*;
#(
  parameter int  ROB_DEPTH = 32,
  parameter int  DISP_W    = 2,
  parameter int  COMMIT_W  = 2,
  parameter int  CDB_PORTS = 2,
  localparam int IDX_W     = idx_w(ROB_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DISP_W-1:0]                    enq_valid,
  input  rob_entry_t [DISP_W-1:0]              enq_entry,
  output logic                                 enq_ready,
  output logic [DISP_W-1:0][IDX_W-1:0]         enq_idx,
  input  logic [CDB_PORTS-1:0]                 cdb_valid,
  input  logic [CDB_PORTS-1:0][IDX_W-1:0]      cdb_rob_idx,
  input  logic [CDB_PORTS-1:0]                 cdb_redirect,
  input  logic [CDB_PORTS-1:0][31:0]           cdb_target,
  output logic [COMMIT_W-1:0]                  commit_valid,
  output logic [COMMIT_W-1:0][4:0]             commit_rd,
  output logic [COMMIT_W-1:0][PREG_W-1:0]      commit_pd,
  output logic                                 flush,
  output logic [31:0]                          flush_pc,
  output logic [IDX_W-1:0]                     head_idx,
  output logic [IDX_W:0]                       count
);

  // Control state (reset)
  logic [ROB_DEPTH-1:0] valid_reg;
  logic [ROB_DEPTH-1:0] done_reg;
  logic [ROB_DEPTH-1:0] redirect_reg;
  logic [IDX_W:0]       head_reg;
  logic [IDX_W:0]       tail_reg;
  logic [IDX_W:0]       count_reg;
  logic                 flush_reg;
  logic [31:0]          flush_pc_reg;
  logic [COMMIT_W-1:0]              commit_valid_reg;
  logic [COMMIT_W-1:0][4:0]         commit_rd_reg;
  logic [COMMIT_W-1:0][PREG_W-1:0]  commit_pd_reg;

  // Payload storage (no reset; only read when the matching valid bit is set)
  logic [31:0]       target_mem [ROB_DEPTH];
  logic [4:0]        rd_mem     [ROB_DEPTH];
  logic [PREG_W-1:0] pd_mem     [ROB_DEPTH];

  logic [COMMIT_W-1:0][IDX_W-1:0] lane_idx;
  logic [COMMIT_W-1:0] lane_occupied;
  logic [COMMIT_W-1:0] lane_done;
  logic [COMMIT_W-1:0] lane_redirect;
  logic [COMMIT_W-1:0] retire;
  logic [2:0]          retire_count;
  logic                redirect_hit;
  logic [31:0]         redirect_target;
  logic                squash;
  logic [DISP_W-1:0]   enq_fire;
  logic [2:0]          enq_count;
  logic [CDB_PORTS-1:0] port_win;
  logic                unused_is_branch;

  // Inputs are dropped both in the cycle a redirect retires and in the flush cycle.
  assign squash = redirect_hit | flush_reg;

  // Only registered occupancy counts; same-cycle retirements do not free slots.
  assign enq_ready = ((int'(count_reg) + DISP_W) <= ROB_DEPTH) && !squash;

  genvar gi;

  generate
    for (gi = 0; gi < COMMIT_W; gi++) begin : g_lane
      assign lane_idx[gi]      = head_reg[IDX_W-1:0] + IDX_W'(gi);
      assign lane_occupied[gi] = valid_reg[lane_idx[gi]];
      assign lane_done[gi]     = done_reg[lane_idx[gi]];
      assign lane_redirect[gi] = redirect_reg[lane_idx[gi]];
    end

    for (gi = 0; gi < DISP_W; gi++) begin : g_disp
      assign enq_idx[gi]  = tail_reg[IDX_W-1:0] + IDX_W'(gi);
      assign enq_fire[gi] = enq_ready && enq_valid[gi];
    end

    // A port loses to any lower-numbered valid port naming the same entry.
    for (gi = 0; gi < CDB_PORTS; gi++) begin : g_cdb
      logic shadowed;
      always_comb begin
        shadowed = 1'b0;
        for (int q = 0; q < gi; q++) begin
          if (cdb_valid[q] && (cdb_rob_idx[q] == cdb_rob_idx[gi])) shadowed = 1'b1;
        end
      end
      assign port_win[gi] = cdb_valid[gi] && !shadowed && !squash &&
                            valid_reg[cdb_rob_idx[gi]] && !done_reg[cdb_rob_idx[gi]];
    end
  endgenerate

  rob_commit_select #(.COMMIT_W(COMMIT_W)) u_commit_select (
    .lane_occupied (lane_occupied),
    .lane_done     (lane_done),
    .lane_redirect (lane_redirect),
    .retire        (retire),
    .retire_count  (retire_count),
    .redirect_hit  (redirect_hit)
  );

  always_comb begin
    redirect_target = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (retire[j] && lane_redirect[j]) redirect_target = target_mem[lane_idx[j]];
    end
  end

  always_comb begin
    enq_count = '0;
    for (int k = 0; k < DISP_W; k++) enq_count = enq_count + 3'(enq_fire[k]);
  end

  // is_branch travels with the entry for other consumers; the ROB does not need it.
  always_comb begin
    unused_is_branch = 1'b0;
    for (int k = 0; k < DISP_W; k++) unused_is_branch = unused_is_branch ^ enq_entry[k].is_branch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg        <= '0;
      done_reg         <= '0;
      redirect_reg     <= '0;
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      flush_reg        <= 1'b0;
      flush_pc_reg     <= '0;
      commit_valid_reg <= '0;
      commit_rd_reg    <= '0;
      commit_pd_reg    <= '0;
    end else begin
      flush_reg <= redirect_hit;
      if (redirect_hit) flush_pc_reg <= redirect_target;

      for (int j = 0; j < COMMIT_W; j++) begin
        commit_valid_reg[j] <= retire[j];
        commit_rd_reg[j]    <= retire[j] ? rd_mem[lane_idx[j]] : '0;
        commit_pd_reg[j]    <= retire[j] ? pd_mem[lane_idx[j]] : '0;
      end

      if (redirect_hit) begin
        valid_reg    <= '0;
        done_reg     <= '0;
        redirect_reg <= '0;
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
      end else begin
        // Retiring entries are done, CDB winners are not done, dispatch targets
        // are free: the three updates never touch the same entry.
        for (int j = 0; j < COMMIT_W; j++) begin
          if (retire[j]) begin
            valid_reg[lane_idx[j]] <= 1'b0;
            done_reg[lane_idx[j]]  <= 1'b0;
          end
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (port_win[p]) begin
            done_reg[cdb_rob_idx[p]]     <= 1'b1;
            redirect_reg[cdb_rob_idx[p]] <= cdb_redirect[p];
          end
        end
        for (int k = 0; k < DISP_W; k++) begin
          if (enq_fire[k]) begin
            valid_reg[enq_idx[k]]    <= 1'b1;
            done_reg[enq_idx[k]]     <= 1'b0;
            redirect_reg[enq_idx[k]] <= 1'b0;
          end
        end
        head_reg  <= head_reg + (IDX_W+1)'(retire_count);
        tail_reg  <= tail_reg + (IDX_W+1)'(enq_count);
        count_reg <= count_reg + (IDX_W+1)'(enq_count) - (IDX_W+1)'(retire_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DISP_W; k++) begin
      if (enq_fire[k]) begin
        rd_mem[enq_idx[k]] <= enq_entry[k].areg_index;
        pd_mem[enq_idx[k]] <= enq_entry[k].preg_index;
      end
    end
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (port_win[p]) target_mem[cdb_rob_idx[p]] <= cdb_target[p];
    end
  end

  assign commit_valid = commit_valid_reg;
  assign commit_rd    = commit_rd_reg;
  assign commit_pd    = commit_pd_reg;
  assign flush        = flush_reg;
  assign flush_pc     = flush_pc_reg;
  assign head_idx     = head_reg[IDX_W-1:0];
  assign count        = count_reg;

endmodule

// File: tb/tb_rob_superscalar.sv
// Self-checking bench for rob_superscalar (depth 8, two-wide everywhere).
// The reference model keeps in-flight instructions as a queue, oldest first.
module tb_rob_superscalar;
  import rv32i_types::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]               enq_valid;
  rob_entry_t [1:0]         enq_entry;
  logic                     enq_ready;
  logic [1:0][2:0]          enq_idx;
  logic [1:0]               cdb_valid;
  logic [1:0][2:0]          cdb_rob_idx;
  logic [1:0]               cdb_redirect;
  logic [1:0][31:0]         cdb_target;
  logic [1:0]               commit_valid;
  logic [1:0][4:0]          commit_rd;
  logic [1:0][PREG_W-1:0]   commit_pd;
  logic                     flush;
  logic [31:0]              flush_pc;
  logic [2:0]               head_idx;
  logic [3:0]               count;

  always #5 clk = ~clk;

  rob_superscalar #(.ROB_DEPTH(8), .DISP_W(2), .COMMIT_W(2), .CDB_PORTS(2)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_entry(enq_entry), .enq_ready(enq_ready), .enq_idx(enq_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_redirect(cdb_redirect),
    .cdb_target(cdb_target),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd(commit_pd),
    .flush(flush), .flush_pc(flush_pc), .head_idx(head_idx), .count(count)
  );

  typedef struct {
    int               idx;
    logic [4:0]       rd;
    logic [PREG_W-1:0] pd;
    bit               done;
    bit               redir;
    logic [31:0]      tgt;
  } ment_t;

  ment_t mq[$];
  int    m_head, m_tail;
  bit    m_flush;
  logic [31:0] m_flush_pc;
  logic [1:0]             e_cv;
  logic [1:0][4:0]        e_rd;
  logic [1:0][PREG_W-1:0] e_pd;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    enq_valid    = '0;
    enq_entry    = '0;
    cdb_valid    = '0;
    cdb_rob_idx  = '0;
    cdb_redirect = '0;
    cdb_target   = '0;
  endtask

  function automatic void model_reset();
    mq.delete();
    m_head = 0; m_tail = 0; m_flush = 0; m_flush_pc = '0;
    e_cv = '0; e_rd = '0; e_pd = '0;
  endfunction

  // Oldest done instructions retire, at most two, stopping after a redirect.
  function automatic void m_retire_scan(output int n, output bit rr);
    n = 0; rr = 0;
    for (int j = 0; j < 2; j++) begin
      if (j >= mq.size()) break;
      if (!mq[j].done) break;
      n++;
      if (mq[j].redir) begin rr = 1; break; end
    end
  endfunction

  function automatic bit model_ready();
    int n; bit rr;
    m_retire_scan(n, rr);
    return (mq.size() + 2 <= D) && !m_flush && !rr;
  endfunction

  function automatic void model_update(input bit rdy);
    int n; bit rr; bit was_flush; ment_t x;
    m_retire_scan(n, rr);
    e_cv = '0; e_rd = '0; e_pd = '0;
    for (int j = 0; j < n; j++) begin
      e_cv[j] = 1'b1; e_rd[j] = mq[j].rd; e_pd[j] = mq[j].pd;
    end
    was_flush = m_flush;
    m_flush = 0;
    if (rr) begin
      m_flush = 1;
      m_flush_pc = mq[n-1].tgt;
      mq.delete();
      m_head = 0; m_tail = 0;
      return;
    end
    if (!was_flush) begin
      for (int p = 0; p < 2; p++) begin
        if (cdb_valid[p] && !(p == 1 && cdb_valid[0] && cdb_rob_idx[0] == cdb_rob_idx[1])) begin
          foreach (mq[e]) begin
            if (mq[e].idx == int'(cdb_rob_idx[p]) && !mq[e].done) begin
              mq[e].done = 1; mq[e].redir = cdb_redirect[p]; mq[e].tgt = cdb_target[p];
            end
          end
        end
      end
    end
    repeat (n) void'(mq.pop_front());
    m_head = (m_head + n) % D;
    if (rdy) begin
      for (int k = 0; k < 2; k++) begin
        if (enq_valid[k]) begin
          x.idx = m_tail; x.rd = enq_entry[k].areg_index; x.pd = enq_entry[k].preg_index;
          x.done = 0; x.redir = 0; x.tgt = '0;
          mq.push_back(x);
          m_tail = (m_tail + 1) % D;
        end
      end
    end
  endfunction

  // One clock: check pre-edge outputs, advance model, clock, check post-edge outputs.
  task automatic step(input string name);
    bit rdy;
    logic [5:0] exp_idx;
    #1;
    rdy = model_ready();
    exp_idx = {3'((m_tail + 1) % D), 3'(m_tail % D)};
    chk({name, ".enq_ready"}, 64'(enq_ready), 64'(rdy));
    chk({name, ".enq_idx"}, 64'(enq_idx), 64'(exp_idx));
    model_update(rdy);
    @(posedge clk); #1;
    chk({name, ".commit_valid"}, 64'(commit_valid), 64'(e_cv));
    chk({name, ".commit_rd"}, 64'(commit_rd), 64'(e_rd));
    chk({name, ".commit_pd"}, 64'(commit_pd), 64'(e_pd));
    chk({name, ".flush"}, 64'(flush), 64'(m_flush));
    if (m_flush) chk({name, ".flush_pc"}, 64'(flush_pc), 64'(m_flush_pc));
    chk({name, ".count"}, 64'(count), 64'(mq.size()));
    chk({name, ".head_idx"}, 64'(head_idx), 64'(m_head));
    $display("step %s: cv=%b flush=%b count=%0d head=%0d", name, commit_valid, flush, count, head_idx);
    idle();
  endtask

  task automatic disp(input logic [1:0] v);
    enq_valid = v;
    for (int k = 0; k < 2; k++) begin
      enq_entry[k].areg_index = 5'(m_tail + k + 1);
      enq_entry[k].preg_index = PREG_W'(m_tail + k + 10);
      enq_entry[k].is_branch  = 1'b0;
    end
  endtask

  task automatic cdb(input int port, input int idx, input bit redir, input logic [31:0] tgt);
    cdb_valid[port]    = 1'b1;
    cdb_rob_idx[port]  = 3'(idx);
    cdb_redirect[port] = redir;
    cdb_target[port]   = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    int sz;
    idle();
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.commit_valid", 64'(commit_valid), 64'd0);
    chk("reset.commit_rd", 64'(commit_rd), 64'd0);
    chk("reset.commit_pd", 64'(commit_pd), 64'd0);
    chk("reset.flush", 64'(flush), 64'd0);
    chk("reset.flush_pc", 64'(flush_pc), 64'd0);
    chk("reset.enq_ready", 64'(enq_ready), 64'd1);
    chk("reset.head_idx", 64'(head_idx), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill an 8-entry ROB with four pairs.
    for (int i = 0; i < 4; i++) begin
      chk("fill.enq_idx_const", 64'(enq_idx), 64'({3'(2*i+1), 3'(2*i)}));
      disp(2'b11);
      step("fill");
    end
    chk("full.count", 64'(count), 64'd8);
    chk("full.enq_ready", 64'(enq_ready), 64'd0);

    // Out-of-order completion; dispatch attempted while full and retiring.
    cdb(0, 1, 0, 32'h0); step("ooo1");
    cdb(0, 0, 0, 32'h0); step("ooo0");
    disp(2'b11); step("ooo_retire");
    chk("ooo.commit_valid", 64'(commit_valid), 64'b11);
    chk("ooo.lane0_rd", 64'(commit_rd[0]), 64'd1);
    chk("ooo.lane0_pd", 64'(commit_pd[0]), 64'd10);
    chk("ooo.count", 64'(count), 64'd6);

    // Redirect on entry 1 with 0..3 done; inputs during redirect/flush discarded.
    do_reset();
    disp(2'b11); step("rd_fill");
    disp(2'b11); step("rd_fill");
    cdb(0, 2, 0, 32'h0); cdb(1, 3, 0, 32'h0); step("rd_cdb23");
    cdb(0, 0, 0, 32'h0); cdb(1, 1, 1, 32'h0000_1040); step("rd_cdb01");
    disp(2'b11); cdb(0, 2, 1, 32'hdead_0000); step("rd_retire");
    chk("rd.commit_valid", 64'(commit_valid), 64'b11);
    chk("rd.flush", 64'(flush), 64'd1);
    chk("rd.flush_pc", 64'(flush_pc), 64'h1040);
    chk("rd.count", 64'(count), 64'd0);
    chk("rd.flush_enq_ready", 64'(enq_ready), 64'd0);
    disp(2'b11); step("rd_flush");
    chk("rd.after_flush", 64'(flush), 64'd0);
    chk("rd.after_count", 64'(count), 64'd0);

    // Wrap-around retirement across entry 7 -> 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin disp(2'b11); step("wr_fill"); end
    cdb(0, 0, 0, 0); cdb(1, 1, 0, 0); step("wr_c01");
    cdb(0, 2, 0, 0); cdb(1, 3, 0, 0); step("wr_c23");
    cdb(0, 4, 0, 0); cdb(1, 5, 0, 0); step("wr_c45");
    cdb(0, 6, 0, 0); step("wr_c6");
    step("wr_idle"); step("wr_idle");
    chk("wr.head7", 64'(head_idx), 64'd7);
    chk("wr.count1", 64'(count), 64'd1);
    chk("wr.enq_idx_wrap", 64'(enq_idx), 64'({3'd1, 3'd0}));
    disp(2'b11); step("wr_disp");
    cdb(0, 7, 0, 0); cdb(1, 0, 0, 0); step("wr_c70");
    step("wr_retire");
    chk("wr.commit_valid", 64'(commit_valid), 64'b11);
    chk("wr.commit_rd", 64'(commit_rd), 64'({5'd1, 5'd8}));
    chk("wr.head1", 64'(head_idx), 64'd1);

    // Both ports name entry 3; port 0 (redirect) wins.
    do_reset();
    disp(2'b11); step("pp_fill");
    disp(2'b11); step("pp_fill");
    cdb(0, 0, 0, 0); cdb(1, 1, 0, 0); step("pp_c01");
    cdb(0, 2, 0, 0); step("pp_c2");
    cdb(0, 3, 1, 32'h0000_2000); cdb(1, 3, 0, 32'h0000_3000); step("pp_c3");
    step("pp_retire");
    chk("pp.commit_valid", 64'(commit_valid), 64'b01);
    chk("pp.flush", 64'(flush), 64'd1);
    chk("pp.flush_pc", 64'(flush_pc), 64'h2000);

    // Asynchronous reset with five in flight and a redirect pending.
    do_reset();
    disp(2'b11); step("ar_fill");
    disp(2'b11); step("ar_fill");
    disp(2'b01); step("ar_fill");
    cdb(0, 4, 1, 32'h0000_5000); step("ar_cdb");
    rst = 1'b1;
    #1;
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.commit_valid", 64'(commit_valid), 64'd0);
    chk("arst.commit_rd", 64'(commit_rd), 64'd0);
    chk("arst.flush", 64'(flush), 64'd0);
    chk("arst.flush_pc", 64'(flush_pc), 64'd0);
    chk("arst.enq_ready", 64'(enq_ready), 64'd1);
    chk("arst.head_idx", 64'(head_idx), 64'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("arst.hold_flush", 64'(flush), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 3));
      enq_valid = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      for (int k = 0; k < 2; k++) begin
        enq_entry[k].areg_index = 5'($urandom);
        enq_entry[k].preg_index = PREG_W'($urandom);
        enq_entry[k].is_branch  = 1'($urandom);
      end
      sz = mq.size();
      for (int p = 0; p < 2; p++) begin
        cdb_valid[p] = 1'($urandom_range(0, 1));
        if (sz > 0 && $urandom_range(0, 9) != 0)
          cdb_rob_idx[p] = 3'(mq[$urandom_range(0, sz - 1)].idx);
        else
          cdb_rob_idx[p] = 3'($urandom_range(0, 7));
        cdb_redirect[p] = ($urandom_range(0, 11) == 0);
        cdb_target[p]   = $urandom;
      end
      if ($urandom_range(0, 4) == 0) cdb_rob_idx[1] = cdb_rob_idx[0];
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
